// File: rtl/bsg_mcl_pkg.sv
// Manycore-link FIFO word formats and op encodings, shared by the FIFO bridge
// and the FIFO responder.
package bsg_mcl_pkg;

    typedef enum logic [7:0] {
        ePacketOp_remote_load  = 8'd0,
        ePacketOp_remote_store = 8'd1
    } bsg_mcl_packet_op_e;

    typedef enum logic [7:0] {
        ePacketType_credit = 8'd0,
        ePacketType_data   = 8'd1
    } bsg_mcl_packet_type_e;

    localparam int bsg_mcl_fifo_width_gp = 128;

    // op is kept as a raw byte so that unknown encodings survive into the responder.
    typedef struct packed {
        logic [15:0] padding;
        logic [31:0] addr;
        logic [7:0]  op;
        logic [7:0]  op_ex;
        logic [31:0] payload;
        logic [7:0]  src_y;
        logic [7:0]  src_x;
        logic [7:0]  y;
        logic [7:0]  x;
    } bsg_mcl_request_s;

    typedef struct packed {
        logic [39:0]          padding;
        bsg_mcl_packet_type_e pkt_type;
        logic [31:0]          data;
        logic [31:0]          load_id;
        logic [7:0]           y_cord;
        logic [7:0]           x_cord;
    } bsg_mcl_response_s;

    function automatic logic bsg_mcl_addr_in_range(input logic [31:0] addr,
                                                   input int unsigned els);
        return addr < 32'(els);
    endfunction

endpackage

// File: rtl/bsg_mcl_fifo_responder_if.sv
// Request/response FIFO handshake bundle between a host FIFO and the responder.
interface bsg_mcl_fifo_responder_if #(
    parameter int fifo_width_p = 128
);
    logic                    req_v_i;
    logic [fifo_width_p-1:0] req_data_i;
    logic                    req_ready_o;
    logic                    rsp_v_o;
    logic [fifo_width_p-1:0] rsp_data_o;
    logic                    rsp_ready_i;

    modport master (
        output req_v_i, req_data_i, rsp_ready_i,
        input  req_ready_o, rsp_v_o, rsp_data_o
    );

    modport slave (
        input  req_v_i, req_data_i, rsp_ready_i,
        output req_ready_o, rsp_v_o, rsp_data_o
    );
endinterface

// File: rtl/bsg_mcl_responder_mem.sv
// 1RW synchronous word memory with per-byte write mask; read data is registered.
module bsg_mcl_responder_mem #(
    parameter int width_p = 32,
    parameter int els_p   = 1024,
    localparam int addr_width_lp = $clog2(els_p),
    localparam int mask_width_lp = width_p / 8
) (
    input  logic                     clk_i,
    input  logic                     v_i,
    input  logic                     w_i,
    input  logic [addr_width_lp-1:0] addr_i,
    input  logic [width_p-1:0]       data_i,
    input  logic [mask_width_lp-1:0] w_mask_i,
    output logic [width_p-1:0]       data_o
);
    logic [width_p-1:0] mem_q [els_p];
    logic [width_p-1:0] data_q;

    always_ff @(posedge clk_i) begin
        if (v_i && w_i) begin
            for (int b = 0; b < mask_width_lp; b++) begin
                if (w_mask_i[b]) begin
                    mem_q[addr_i][b*8 +: 8] <= data_i[b*8 +: 8];
                end
            end
        end else if (v_i) begin
            data_q <= mem_q[addr_i];
        end
    end

    assign data_o = data_q;
endmodule

// File: rtl/bsg_mcl_fifo_responder.sv
// Manycore-link FIFO responder: executes remote loads/stores against local memory.
// Optional destination check enabled by BSG_MCL_RESPONDER_COORD_CHECK_EN.
module bsg_mcl_fifo_responder #(
    parameter int fifo_width_p    = 128,
    parameter int data_width_p    = 32,
    parameter int mem_els_p       = 1024,
    parameter int load_id_width_p = 11,
    parameter int x_cord_width_p  = 6,
    parameter int y_cord_width_p  = 5
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    bsg_mcl_fifo_responder_if.slave    fifo_if,
    input  logic [x_cord_width_p-1:0]  my_x_i,
    input  logic [y_cord_width_p-1:0]  my_y_i,
    output logic                       store_ack_v_o,
    output logic [15:0]                err_count_o,
    output logic                       busy_o
);
    import bsg_mcl_pkg::*;

    localparam int addr_width_lp = $clog2(mem_els_p);
    localparam int mask_width_lp = data_width_p / 8;

    typedef enum logic [1:0] {
        e_idle,
        e_read,
        e_resp
    } state_e;

    state_e                     state_q, state_d;
    logic                       rsp_v_q, rsp_v_d;
    bsg_mcl_response_s          rsp_data_q, rsp_data_d;
    logic [15:0]                err_count_q, err_count_d;
    logic [load_id_width_p-1:0] load_id_q;
    logic [x_cord_width_p-1:0]  src_x_q;
    logic [y_cord_width_p-1:0]  src_y_q;

    bsg_mcl_request_s           req;
    logic                       accept, is_load, is_store, addr_bad, coord_bad, drop;
    logic                       load_go;
    logic [data_width_p-1:0]    mem_rdata;

    assign req = bsg_mcl_request_s'(fifo_if.req_data_i[$bits(bsg_mcl_request_s)-1:0]);

    // Gating with the reset pin keeps ready low while held in reset.
    assign fifo_if.req_ready_o = reset_n_i && (state_q == e_idle);
    assign accept              = fifo_if.req_v_i && fifo_if.req_ready_o;

    assign is_load  = (req.op == ePacketOp_remote_load);
    assign is_store = (req.op == ePacketOp_remote_store);
    assign addr_bad = !bsg_mcl_addr_in_range(req.addr, mem_els_p);

`ifdef BSG_MCL_RESPONDER_COORD_CHECK_EN
    assign coord_bad = (req.x[x_cord_width_p-1:0] != my_x_i)
                    || (req.y[y_cord_width_p-1:0] != my_y_i);
    logic unused_fields;
    assign unused_fields = ^{req.padding, req.op_ex[7:mask_width_lp],
                             req.src_x[7:x_cord_width_p], req.src_y[7:y_cord_width_p],
                             req.x[7:x_cord_width_p], req.y[7:y_cord_width_p]};
`else
    assign coord_bad = 1'b0;
    logic unused_fields;
    assign unused_fields = ^{req.padding, req.op_ex[7:mask_width_lp],
                             req.src_x[7:x_cord_width_p], req.src_y[7:y_cord_width_p],
                             req.x, req.y, my_x_i, my_y_i};
`endif

    assign drop          = (!is_load && !is_store) || addr_bad || coord_bad;
    assign store_ack_v_o = accept && is_store && !drop;
    assign load_go       = accept && is_load && !drop;

    bsg_mcl_responder_mem #(
        .width_p (data_width_p),
        .els_p   (mem_els_p)
    ) mem (
        .clk_i    (clk_i),
        .v_i      (accept && !drop),
        .w_i      (is_store),
        .addr_i   (req.addr[addr_width_lp-1:0]),
        .data_i   (req.payload[data_width_p-1:0]),
        .w_mask_i (req.op_ex[mask_width_lp-1:0]),
        .data_o   (mem_rdata)
    );

    always_comb begin
        state_d    = state_q;
        rsp_v_d    = rsp_v_q;
        rsp_data_d = rsp_data_q;
        unique case (state_q)
            e_idle: begin
                if (load_go) state_d = e_read;
            end
            e_read: begin
                state_d             = e_resp;
                rsp_v_d             = 1'b1;
                rsp_data_d          = '0;
                rsp_data_d.pkt_type = ePacketType_data;
                rsp_data_d.data     = 32'(mem_rdata);
                rsp_data_d.load_id  = 32'(load_id_q);
                rsp_data_d.y_cord   = 8'(src_y_q);
                rsp_data_d.x_cord   = 8'(src_x_q);
            end
            e_resp: begin
                if (fifo_if.rsp_ready_i) begin
                    state_d = e_idle;
                    rsp_v_d = 1'b0;
                end
            end
            default: state_d = e_idle;
        endcase
    end

    always_comb begin
        err_count_d = err_count_q;
        if (accept && drop && (err_count_q != 16'hFFFF)) begin
            err_count_d = err_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= e_idle;
            rsp_v_q     <= 1'b0;
            rsp_data_q  <= '0;
            err_count_q <= '0;
            load_id_q   <= '0;
            src_x_q     <= '0;
            src_y_q     <= '0;
        end else begin
            state_q     <= state_d;
            rsp_v_q     <= rsp_v_d;
            rsp_data_q  <= rsp_data_d;
            err_count_q <= err_count_d;
            if (load_go) begin
                load_id_q <= req.payload[load_id_width_p-1:0];
                src_x_q   <= req.src_x[x_cord_width_p-1:0];
                src_y_q   <= req.src_y[y_cord_width_p-1:0];
            end
        end
    end

    assign fifo_if.rsp_v_o    = rsp_v_q;
    assign fifo_if.rsp_data_o = rsp_data_q;
    assign err_count_o        = err_count_q;
    assign busy_o             = (state_q != e_idle);
endmodule

// File: tb/tb_bsg_mcl_fifo_responder.sv
// Randomized self-checking bench for bsg_mcl_fifo_responder with a transaction-level model.
module tb_bsg_mcl_fifo_responder;
    import bsg_mcl_pkg::*;

    localparam int MEM_ELS = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ack;
    logic [15:0] err;
    logic        busy;

    bsg_mcl_fifo_responder_if #(.fifo_width_p(128)) fif ();

    bsg_mcl_fifo_responder dut (
        .clk_i         (clk),
        .reset_n_i     (rst_n),
        .fifo_if       (fif),
        .my_x_i        (6'd1),
        .my_y_i        (5'd1),
        .store_ack_v_o (ack),
        .err_count_o   (err),
        .busy_o        (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] bytes_to_bits(input logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

    function automatic bsg_mcl_request_s mk(input logic [7:0] op, input logic [31:0] addr,
                                            input logic [7:0] op_ex, input logic [31:0] payload,
                                            input logic [7:0] sx, input logic [7:0] sy,
                                            input logic [7:0] x, input logic [7:0] y);
        bsg_mcl_request_s r;
        r = '0;
        r.op = op; r.addr = addr; r.op_ex = op_ex; r.payload = payload;
        r.src_x = sx; r.src_y = sy; r.x = x; r.y = y;
        return r;
    endfunction

    // ---------------- behavioural model ----------------
    logic [31:0] mmem [int];
    logic [3:0]  mval [int];
    bit          outstanding = 0;
    int          acc_cyc = 0;
    logic [15:0] exp_err = 0;
    logic [31:0] exp_data;
    logic [3:0]  exp_mask;
    logic [31:0] exp_lid;
    logic [7:0]  exp_x, exp_y;
    bit          hold_prev = 0;
    logic [127:0] prev_data;
    bit          last_accept = 0;
    int          ack_seen = 0;

    bit                m_acc, m_load, m_store, m_bad, exp_v;
    bsg_mcl_request_s  q;
    bsg_mcl_response_s r;
    logic [31:0]       bm;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_rsp_v", fif.rsp_v_o, 0);
            chk("rst_rsp_data", fif.rsp_data_o, 0);
            chk("rst_ack", ack, 0);
            chk("rst_err", err, 0);
            chk("rst_busy", busy, 0);
            outstanding = 0;
            exp_err     = 0;
            hold_prev   = 0;
            last_accept = 0;
        end else begin
            exp_v = outstanding && (cyc >= acc_cyc + 2);
            chk("rsp_v", fif.rsp_v_o, exp_v);
            chk("req_ready", fif.req_ready_o, !outstanding);
            chk("busy", busy, outstanding);
            chk("err_count", err, exp_err);
            if (hold_prev) begin
                chk("rsp_hold_v", fif.rsp_v_o, 1);
                chk("rsp_hold_data", fif.rsp_data_o, prev_data);
            end
            if (fif.rsp_v_o && exp_v) begin
                r = bsg_mcl_response_s'(fif.rsp_data_o);
                chk("rsp_type", r.pkt_type, ePacketType_data);
                chk("rsp_load_id", r.load_id, exp_lid);
                chk("rsp_x", r.x_cord, exp_x);
                chk("rsp_y", r.y_cord, exp_y);
                chk("rsp_pad", r.padding, 0);
                if (exp_mask != 4'h0) begin
                    bm = bytes_to_bits(exp_mask);
                    chk("rsp_data", r.data & bm, exp_data & bm);
                end
            end

            q       = bsg_mcl_request_s'(fif.req_data_i);
            m_acc   = fif.req_v_i && fif.req_ready_o;
            m_load  = (q.op == 8'd0);
            m_store = (q.op == 8'd1);
            m_bad   = (!m_load && !m_store) || (q.addr >= MEM_ELS);
`ifdef BSG_MCL_RESPONDER_COORD_CHECK_EN
            m_bad = m_bad || ((q.x % 64) != 1) || ((q.y % 32) != 1);
`endif
            chk("store_ack", ack, m_acc && m_store && !m_bad);
            if (ack) ack_seen++;

            if (m_acc) begin
                $display("txn cyc=%0d op=%0h addr=%0h opex=%0h payload=%08h %s", cyc, q.op,
                         q.addr, q.op_ex, q.payload,
                         m_bad ? "dropped" : (m_store ? "store" : "load"));
                if (m_bad) begin
                    if (exp_err != 16'hFFFF) exp_err = exp_err + 1;
                end else if (m_store) begin
                    if (!mmem.exists(int'(q.addr))) begin
                        mmem[int'(q.addr)] = 0;
                        mval[int'(q.addr)] = 0;
                    end
                    for (int k = 0; k < 4; k++) begin
                        if (q.op_ex[k]) begin
                            mmem[int'(q.addr)][k*8 +: 8] = q.payload[k*8 +: 8];
                            mval[int'(q.addr)][k]        = 1'b1;
                        end
                    end
                end else begin
                    outstanding = 1;
                    acc_cyc     = cyc;
                    exp_data    = mmem.exists(int'(q.addr)) ? mmem[int'(q.addr)] : 32'h0;
                    exp_mask    = mval.exists(int'(q.addr)) ? mval[int'(q.addr)] : 4'h0;
                    exp_lid     = q.payload % 2048;
                    exp_x       = q.src_x % 64;
                    exp_y       = q.src_y % 32;
                end
            end
            if (fif.rsp_v_o && fif.rsp_ready_i && outstanding && exp_v) outstanding = 0;
            hold_prev   = fif.rsp_v_o && !fif.rsp_ready_i;
            prev_data   = fif.rsp_data_o;
            last_accept = m_acc;
        end
    end

    // ---------------- drivers ----------------
    task automatic send(input bsg_mcl_request_s rq, output int acc);
        acc = -1;
        fif.req_v_i    = 1'b1;
        fif.req_data_i = rq;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (fif.req_ready_o) begin
                acc = cyc;
                break;
            end
        end
        @(posedge clk); #1;
        fif.req_v_i = 1'b0;
        if (acc < 0) begin
            total++; bad++;
            $display("FAIL accept_timeout: got ready=0 for 50 cycles expected ready=1");
        end
    endtask

    task automatic wait_rsp(output int rc, output logic [127:0] d);
        rc = -1;
        d  = '0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (fif.rsp_v_o) begin
                rc = cyc;
                d  = fif.rsp_data_o;
                break;
            end
        end
        if (rc < 0) begin
            total++; bad++;
            $display("FAIL rsp_timeout: got rsp_v=0 for 20 cycles expected rsp_v=1");
        end
    endtask

    function automatic bsg_mcl_request_s rand_req();
        int sel, asel;
        logic [7:0]  op;
        logic [31:0] addr;
        logic [7:0]  x, y;
        sel  = $urandom_range(0, 99);
        op   = (sel < 45) ? 8'd1 : (sel < 88) ? 8'd0 : 8'($urandom_range(2, 255));
        asel = $urandom_range(0, 99);
        addr = (asel < 80) ? 32'($urandom_range(0, 15)) :
               (asel < 88) ? 32'(MEM_ELS - 1) :
               (asel < 94) ? 32'(MEM_ELS) : 32'($urandom);
        x = ($urandom_range(0, 7) == 0) ? 8'($urandom) : {2'($urandom), 6'd1};
        y = ($urandom_range(0, 7) == 0) ? 8'($urandom) : {3'($urandom), 5'd1};
        return mk(op, addr, 8'($urandom), $urandom, 8'($urandom), 8'($urandom), x, y);
    endfunction

    int           a, rc, a0, vcnt;
    logic [127:0] d, d0;
    bsg_mcl_response_s rr;

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 50000 cycles");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        fif.req_v_i = 1'b0;
        fif.req_data_i = '0;
        fif.rsp_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", fif.req_ready_o, 1);
        @(posedge clk); #1;

        // store then load back, with latency and field literals
        send(mk(8'd1, 32'd5, 8'h0F, 32'hDEADBEEF, 0, 0, 1, 1), a);
        send(mk(8'd0, 32'd5, 8'h00, 32'd3, 8'd2, 8'd1, 1, 1), a);
        wait_rsp(rc, d);
        rr = bsg_mcl_response_s'(d);
        chk("t1_latency", rc - a, 2);
        chk("t1_data", rr.data, 32'hDEADBEEF);
        chk("t1_load_id", rr.load_id, 3);
        chk("t1_x", rr.x_cord, 2);
        chk("t1_y", rr.y_cord, 1);
        chk("t1_type", rr.pkt_type, ePacketType_data);
        @(posedge clk); #1;

        // masked store merge
        a0 = ack_seen;
        send(mk(8'd1, 32'd7, 8'h0F, 32'hFFFFFFFF, 0, 0, 1, 1), a);
        send(mk(8'd1, 32'd7, 8'h05, 32'h11223344, 0, 0, 1, 1), a);
        chk("t2_acks", ack_seen - a0, 2);
        send(mk(8'd0, 32'd7, 8'h00, 32'd4, 8'd0, 8'd0, 1, 1), a);
        wait_rsp(rc, d);
        rr = bsg_mcl_response_s'(d);
        chk("t2_data", rr.data, 32'hFF22FF44);
        @(posedge clk); #1;

        // response backpressure
        fif.rsp_ready_i = 1'b0;
        send(mk(8'd0, 32'd5, 8'h00, 32'd9, 8'd3, 8'd4, 1, 1), a);
        wait_rsp(rc, d0);
        rr = bsg_mcl_response_s'(d0);
        chk("t3_data", rr.data, 32'hDEADBEEF);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk("t3_hold_v", fif.rsp_v_o, 1);
            chk("t3_hold_data", fif.rsp_data_o, d0);
            chk("t3_ready_low", fif.req_ready_o, 0);
        end
        @(posedge clk); #1;
        fif.rsp_ready_i = 1'b1;
        @(negedge clk);
        chk("t3_handoff_v", fif.rsp_v_o, 1);
        @(negedge clk);
        chk("t3_v_low", fif.rsp_v_o, 0);
        chk("t3_ready_back", fif.req_ready_o, 1);
        @(posedge clk); #1;

        // out-of-range address and unknown op are dropped
        send(mk(8'd0, 32'(MEM_ELS), 8'h00, 32'd1, 0, 0, 1, 1), a);
        send(mk(8'd7, 32'd3, 8'h0F, 32'd1, 0, 0, 1, 1), a);
        vcnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (fif.rsp_v_o) vcnt++;
        end
        chk("t4_no_rsp", vcnt, 0);
        chk("t4_err", err, 2);
        @(posedge clk); #1;

        // destination mismatch
        a0 = ack_seen;
        send(mk(8'd1, 32'd9, 8'h0F, 32'hCAFEF00D, 0, 0, 8'd2, 8'd1), a);
`ifdef BSG_MCL_RESPONDER_COORD_CHECK_EN
        chk("t5_err", err, 3);
        chk("t5_ack", ack_seen - a0, 0);
`else
        chk("t5_err", err, 2);
        chk("t5_ack", ack_seen - a0, 1);
`endif

        // reset while a load is in READ
        send(mk(8'd0, 32'd5, 8'h00, 32'd1, 0, 0, 1, 1), a);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_rsp_v", fif.rsp_v_o, 0);
        chk("t6_busy", busy, 0);
        chk("t6_err", err, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        vcnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (fif.rsp_v_o) vcnt++;
        end
        chk("t6_no_rsp", vcnt, 0);
        chk("t6_ready", fif.req_ready_o, 1);
        @(posedge clk); #1;

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if (!fif.req_v_i || last_accept) begin
                if ($urandom_range(0, 3) != 0) begin
                    fif.req_v_i    = 1'b1;
                    fif.req_data_i = rand_req();
                end else begin
                    fif.req_v_i = 1'b0;
                end
            end
            fif.rsp_ready_i = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        fif.req_v_i     = 1'b0;
        fif.rsp_ready_i = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bsg_mcl_fifo_responder.md
# bsg_mcl_fifo_responder

Host-FIFO-side responder that terminates request words in the manycore-link FIFO format and returns response words on the paired response FIFO. It consumes 128-bit `bsg_mcl_request_s` words, executes remote loads and stores against a local word-addressed memory, and emits `bsg_mcl_response_s` words for loads. It sits at the far end of a host request FIFO and serves as a host-visible memory target and as the loop-back responder for FIFO-bridge regressions.

## Interface
- `fifo_width_p`, default 128: request and response word width.
- `data_width_p`, default 32: memory word width.
- `mem_els_p`, default 1024: memory depth in words.
- `load_id_width_p`, default 11: load_id bits carried in a load's payload.
- `x_cord_width_p`, default 6; `y_cord_width_p`, default 5: coordinate widths.
- `clk_i  in  1`: clock.
- `reset_n_i  in  1`: reset, asynchronous, active-low. One clock domain only.
- `req_v_i  in  1`, `req_data_i  in  fifo_width_p`, `req_ready_o  out  1`: request FIFO, valid/ready.
- `rsp_v_o  out  1`, `rsp_data_o  out  fifo_width_p`, `rsp_ready_i  in  1`: response FIFO, valid/ready.
- `my_x_i  in  x_cord_width_p`, `my_y_i  in  y_cord_width_p`: this target's coordinates.
- `store_ack_v_o  out  1`: one-cycle pulse per committed store (credit return).
- `err_count_o  out  16`: dropped-request counter.
- `busy_o  out  1`: high whenever the FSM is not IDLE.

## Operation
- Request fields are taken from the package struct: `addr[31:0]`, `op[7:0]`, `op_ex[7:0]` (byte mask), `payload[31:0]`, `src_y/src_x/y/x[7:0]`. Each field is truncated to its parameter width.
- Word index = `addr[$clog2(mem_els_p)-1:0]`. If the upper address bits are nonzero, the address is out of range.
- `op == ePacketOp_remote_store`: for each set bit k in `op_ex[3:0]`, byte k of memory takes byte k of `payload`. `store_ack_v_o` pulses in the accept cycle. No response word is produced.
- `op == ePacketOp_remote_load`: synchronous read. The response word carries:
  - `pkt_type = ePacketType_data`
  - `data` = memory word
  - `load_id = payload[load_id_width_p-1:0]`, zero-extended to 32 bits
  - `y_cord/x_cord = src_y/src_x` of the request
  - `padding = 0`
- The following requests are accepted and dropped: unknown op, out-of-range address, or a coordinate mismatch (see Configuration). For each, `err_count_o` increments and saturates at 16'hFFFF. Dropped requests produce no ack and no response.
- FSM:
  - IDLE: `req_ready_o = 1`. Store or drop stays in IDLE. Load goes to READ.
  - READ: the memory read completes; the response register is loaded; go to RESP.
  - RESP: `rsp_v_o = 1` with `rsp_data_o` held stable. When `rsp_ready_i = 1`, go to IDLE.
- Only one load is outstanding at a time. `req_ready_o = 0` in READ and RESP.

## Timing
- Reset values: FSM IDLE, `rsp_v_o = 0`, `rsp_data_o = 0`, `store_ack_v_o = 0`, `err_count_o = 0`, `busy_o = 0`. `req_ready_o = 1` once reset deasserts. Memory contents are not reset.
- Store throughput is 1 per cycle. A write is visible to a load accepted in the next cycle.
- Load latency: accept at cycle t, `rsp_v_o` at t+2. Minimum load occupancy is 3 cycles.
- `rsp_v_o` and `rsp_data_o` must not change while `rsp_v_o && !rsp_ready_i`.
- `req_ready_o` does not depend combinationally on `req_v_i`. `rsp_v_o` is registered.
- Reset asserted mid-load: the response is discarded and no partial word appears after reset.

## Configuration
- `BSG_MCL_RESPONDER_COORD_CHECK_EN` defined: a request whose `x/y` differs from `my_x_i/my_y_i` is dropped and counted.
- Undefined: the destination coordinates are ignored. `my_x_i` and `my_y_i` remain ports but are unused.

## Structure
- Shared package `bsg_mcl_pkg` holds `bsg_mcl_request_s`, `bsg_mcl_response_s`, the op encodings (`ePacketOp_remote_load = 0`, `ePacketOp_remote_store = 1`) and `ePacketType_data`. The package is shared with the FIFO bridge.
- One sub-module: `bsg_mcl_responder_mem`, a 1RW synchronous memory with byte write mask.

## Test plan
- Store `addr=5`, `op_ex=4'hF`, `payload=32'hDEADBEEF`. Then load `addr=5`, `load_id=3`, `src=(x 2, y 1)`. Response: `data=DEADBEEF`, `load_id=3`, `x=2`, `y=1`, `pkt_type=data`, `rsp_v_o` asserted 2 cycles after accept.
- Store `32'hFFFFFFFF`, then masked store `op_ex=4'b0101`, `payload=32'h11223344`. Load returns `32'hFF22FF44`. `store_ack_v_o` pulses twice.
- Hold `rsp_ready_i=0` for 10 cycles during RESP. Response stays stable, `req_ready_o=0`, then handoff on the first ready cycle.
- Send load `addr=mem_els_p` and `op=8'h7`. Both requests are accepted, `err_count_o=2`, no response.
- With `BSG_MCL_RESPONDER_COORD_CHECK_EN`, `my=(1,1)`, send a request to `(2,1)`. The request is dropped and `err_count_o` increments. Without the macro, the same request executes normally.
- Assert `reset_n_i` low while in READ. All outputs return to their reset values and no response is emitted afterwards.
